// File: rtl/vga_pixel_fetch.sv
// Two-tick pixel fetch stage behind the VGA timing generator: frame-memory address, point op, aligned syncs.
// Optional 1-pixel white frame around the image window: define VGA_PIXEL_FETCH_BORDER_EN.
module vga_pixel_fetch #(
    parameter int          IMG_W      = 256,
    parameter int          IMG_H      = 256,
    parameter int          X0         = 192,
    parameter int          Y0         = 112,
    parameter int          ADDR_W     = 16,
    parameter int          RD_LATENCY = 1,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic              clk,
    input  logic              btnC,
    input  logic              pix_tick,
    input  logic [9:0]        h_in,
    input  logic [9:0]        v_in,
    input  logic              display_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [1:0]        mode,
    input  logic [3:0]        thresh,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_data,
    output logic [11:0]       rgb,
    output logic              hsync,
    output logic              vsync
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

    logic [9:0]        dx, dy;
    logic              in_win;
    logic              frame_start;
    logic [ADDR_W-1:0] cnt, base, nxt;
    logic              synced;
    logic [1:0]        mode_q;
    logic [3:0]        thresh_q;
    logic              s1_win, s1_disp, s1_hs, s1_vs;
    logic [5:0]        sum;
    logic [3:0]        gray;
    logic [11:0]       proc_px, color;

    assign dx          = h_in - 10'(X0);
    assign dy          = v_in - 10'(Y0);
    assign in_win      = display_in && (int'(dx) < IMG_W) && (int'(dy) < IMG_H);
    assign frame_start = (h_in == 10'd0) && (v_in == 10'd0);
    assign base        = frame_start ? '0 : cnt;
    assign nxt         = (base == LAST) ? '0 : base + 1'b1;

`ifdef VGA_PIXEL_FETCH_BORDER_EN
    logic [9:0] bx, by;
    logic       border, s1_bord;

    // The box one pixel larger on every side, minus the window, is the border ring.
    assign bx     = h_in - 10'(X0 - 1);
    assign by     = v_in - 10'(Y0 - 1);
    assign border = display_in && !in_win
                    && (int'(bx) < IMG_W + 2) && (int'(by) < IMG_H + 2);

    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            s1_bord <= 1'b0;
        end else if (pix_tick) begin
            s1_bord <= border;
        end
    end
`endif

    // Counter only runs once a frame start has been seen since reset.
    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            cnt      <= '0;
            mem_addr <= '0;
            synced   <= 1'b0;
            mode_q   <= 2'b00;
            thresh_q <= 4'd0;
        end else if (pix_tick) begin
            if (frame_start) begin
                cnt      <= '0;
                synced   <= 1'b1;
                mode_q   <= mode;
                thresh_q <= thresh;
            end
            if (in_win && (synced || frame_start)) begin
                mem_addr <= base;
                cnt      <= nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            s1_win  <= 1'b0;
            s1_disp <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
        end else if (pix_tick) begin
            s1_win  <= in_win;
            s1_disp <= display_in;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
        end
    end

    assign sum  = {2'b00, mem_data[11:8]} + {1'b0, mem_data[7:4], 1'b0}
                + {2'b00, mem_data[3:0]};
    assign gray = sum[5:2];

    always_comb begin
        proc_px = mem_data;
        case (mode_q)
            2'b00: proc_px = mem_data;
            2'b01: proc_px = {gray, gray, gray};
            2'b10: proc_px = ~mem_data;
            2'b11: proc_px = (gray >= thresh_q) ? 12'hFFF : 12'h000;
            default: proc_px = mem_data;
        endcase
    end

    always_comb begin
        color = BG_COLOR;
        if (!s1_disp) begin
            color = 12'h000;
        end else if (s1_win) begin
            color = proc_px;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
        end else if (s1_bord) begin
            color = 12'hFFF;
`endif
        end
    end

    // mem_data settles within RD_LATENCY (<=3) clks, well inside one tick period.
    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            rgb   <= 12'h000;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (pix_tick) begin
            rgb   <= color;
            hsync <= s1_hs;
            vsync <= s1_vs;
        end
    end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA timing generator. Consumes its pixel position, display-valid, sync and 25 MHz tick outputs.
- Fetches pixels of a stored image from a synchronous-read frame memory, applies a selectable point operation and drives the Basys3 12-bit RGB pins.
- Delays the sync signals so that RGB, hsync and vsync leave the block time-aligned.

Parameters:
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in lines
- X0, 192, left column of the image window on the 640x480 screen
- Y0, 112, top line of the image window
- ADDR_W, 16, frame-memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- RD_LATENCY, 1, frame-memory read latency in clk cycles; legal range 1..3
- BG_COLOR, 12'h000, colour inside the display area but outside the image window

Ports:
- clk  in  1  100 MHz system clock
- btnC  in  1  asynchronous active-low reset
- pix_tick  in  1  25 MHz enable from timing generator; high for 1 clk every 4 clks
- h_in  in  10  current horizontal pixel count, 0..799
- v_in  in  10  current vertical line count, 0..524
- display_in  in  1  high when the pixel is inside the 640x480 area
- hsync_in  in  1  hsync from timing generator
- vsync_in  in  1  vsync from timing generator
- mode  in  2  processing select: 00 pass, 01 gray, 10 invert, 11 threshold
- thresh  in  4  threshold level for mode 11
- mem_addr  out  ADDR_W  frame-memory read address
- mem_data  in  12  frame-memory read data {r[3:0],g[3:0],b[3:0]}
- rgb  out  12  {vgaRed,vgaGreen,vgaBlue}
- hsync  out  1  aligned hsync
- vsync  out  1  aligned vsync

Behaviour:
- Reset (btnC low, asynchronous): mem_addr=0, rgb=0, hsync=0, vsync=0. All pipeline flags clear. Active mode register = 00, active threshold register = 0.
- All state advances only on clk edges where pix_tick=1. State holds otherwise.
- in_win = display_in && (h_in-X0) < IMG_W && (v_in-Y0) < IMG_H. Both differences are unsigned, so positions left of or above the window compare false.
- Address counter:
  - on tick with h_in==0 and v_in==0: load 0
  - else on tick with in_win=1: increment; after IMG_W*IMG_H-1 it wraps to 0
  - mem_addr is the registered counter value presented for the current in-window pixel
- Frame-boundary latch: mode and thresh are sampled into the active registers only on the tick with h_in==0, v_in==0. A mid-frame change has no effect until the next frame.
- Pipeline, stage 1 (tick N): register in_win, display_in, hsync_in, vsync_in; drive mem_addr.
- Pipeline, stage 2 (tick N+1):
  - capture mem_data; valid because RD_LATENCY <= 3 < tick period
  - compute the colour and register rgb
  - forward the stage-1 sync flags to hsync and vsync
- Total latency: 2 ticks (8 clk) from position inputs to rgb/hsync/vsync. The outputs stay mutually aligned.
- Colour selection:
  - stage-2 display=0: rgb=0 (blanking)
  - display=1, in_win=0: rgb=BG_COLOR
  - otherwise: apply the active mode to mem_data (r,g,b)
- Mode arithmetic:
  - 00: rgb = mem_data
  - 01: gray = (r + 2g + b) >> 2, computed in 6 bits, result 4 bits; rgb = {gray,gray,gray}
  - 10: rgb = {15-r,15-g,15-b}
  - 11: rgb = 12'hFFF if gray >= thresh, else 12'h000
- Reset mid-frame: outputs clear immediately. After release, mem_addr stays 0 until the next frame-start tick reloads the counter, so the first post-reset frame can be misaligned. Alignment is correct from the following frame.

Optional Feature:
- Macro: VGA_PIXEL_FETCH_BORDER_EN
- Defined: a 1-pixel white border (12'hFFF) is drawn on columns X0-1 and X0+IMG_W, and on lines Y0-1 and Y0+IMG_H, spanning X0-1..X0+IMG_W inclusive. The border applies only where display=1, has the same 2-tick latency, and overrides BG_COLOR but never image pixels.
- Undefined: no border logic; those pixels show BG_COLOR.

Test Plan:
- Reset: hold btnC=0 for 10 clk with ticks running -> rgb=0, hsync=0, vsync=0, mem_addr=0; release, then first frame start -> mem_addr=0.
- Address sequence: full frame with default parameters -> mem_addr=0 at (192,112), 255 at (447,112), 256 at (192,113), 65535 at (447,367); exactly 65536 increments per frame.
- Mode 00, mem_data=12'hA5C at (200,150) -> rgb=12'hA5C 2 ticks later; background (10,10) -> rgb=BG_COLOR; h=650 -> rgb=0.
- Modes 01/10/11 with mem_data=12'hF80, thresh=8:
  - mode 01 -> gray = (15+16+0)>>2 = 7, rgb=12'h777
  - mode 10 -> rgb=12'h07F
  - mode 11 -> rgb=12'h000
- Mode change mid-frame at v=200 from 00 to 10 -> rest of frame unchanged; inverted from the next frame's first pixel.
- Sync alignment: hsync_in rises at h=656 -> hsync rises exactly 8 clk later. vsync_in high for lines 490-491 -> vsync high for exactly 2 lines, same 8-clk delay.
